// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Control bundle between the RISC_TOY pipeline and its hazard controller.
//   master : pipeline side. Drives the ID-stage decode info, the branch
//            resolution and the memory-busy indication. Reads back the
//            enables, flush/bubble/freeze controls, forwarding selects and
//            performance counters.
//   slave  : hazard controller side.
//   Ports (names as seen by the controller):
//     i_id_valid              valid instruction in ID
//     i_id_ra0_en / i_id_ra0  source 0 read enable / address
//     i_id_ra1_en / i_id_ra1  source 1 read enable / address
//     i_id_wen / i_id_wa      destination write enable / address
//     i_id_load               ID instruction is a load (data at end of MEM)
//     i_ex_br_taken           branch/jump in EX resolved taken
//     i_mem_busy              data memory not ready, whole pipe holds
//     i_cnt_clr               synchronous clear of both counters
//     o_pc_en, o_ifid_en      PC / IF-ID register enables
//     o_ifid_flush            load NOP into IF/ID
//     o_idex_bubble           load NOP into ID/EX
//     o_pipe_freeze           hold ID/EX, EX/MEM, MEM/WB
//     o_fwd_a, o_fwd_b        EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//     o_stall_cnt             cycles lost to data-hazard stalls
//     o_flush_cnt             taken-branch flushes
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             i_id_valid;
  logic             i_id_ra0_en;
  logic [AW-1:0]    i_id_ra0;
  logic             i_id_ra1_en;
  logic [AW-1:0]    i_id_ra1;
  logic             i_id_wen;
  logic [AW-1:0]    i_id_wa;
  logic             i_id_load;
  logic             i_ex_br_taken;
  logic             i_mem_busy;
  logic             i_cnt_clr;

  logic             o_pc_en;
  logic             o_ifid_en;
  logic             o_ifid_flush;
  logic             o_idex_bubble;
  logic             o_pipe_freeze;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_valid, i_id_ra0_en, i_id_ra0, i_id_ra1_en, i_id_ra1,
           i_id_wen, i_id_wa, i_id_load, i_ex_br_taken, i_mem_busy, i_cnt_clr,
    input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_freeze,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_valid, i_id_ra0_en, i_id_ra0, i_id_ra1_en, i_id_ra1,
           i_id_wen, i_id_wa, i_id_load, i_ex_br_taken, i_mem_busy, i_cnt_clr,
    output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_freeze,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard/interlock controller for the 5-stage RISC_TOY pipeline.
//   Shadows the destination of every instruction in EX, MEM and WB, and from
//   that decides load-use/RAW stalls, taken-branch flushes, memory freezes and
//   the EX-stage ALU operand forwarding selects. Owns no datapath.
//   Parameters:
//     AW     register address width
//     FWD_EN 1: forward from EX/MEM and MEM/WB, only load-use stalls
//            0: no forwarding, stall until producer has left WB, FWD = 00
//     CNT_W  performance counter width (counters saturate)
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     io_hz  pipe_hazard_ctrl_if.slave control bundle
// ---------------------------------------------------------------------------

// Forwarding select for one EX operand, from the registered MEM/WB shadows.
//   o_sel = 01 when the EX/MEM result is the youngest producer,
//           10 when the MEM/WB result is, 00 otherwise.
module pipe_hazard_fwd_sel #(
  parameter int AW = 5
) (
  input  logic          i_src_en,
  input  logic [AW-1:0] i_src,
  input  logic          i_mem_v,
  input  logic          i_mem_load,
  input  logic [AW-1:0] i_mem_wa,
  input  logic          i_wb_v,
  input  logic [AW-1:0] i_wb_wa,
  output logic [1:0]    o_sel
);
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_src_en & i_mem_v & (i_mem_wa == i_src);
  assign w_wb_hit  = i_src_en & i_wb_v  & (i_wb_wa  == i_src);

  always_comb begin
    o_sel = 2'b00;
    // A load sitting in MEM has no data yet; the load-use stall keeps this
    // from happening. If it ever does, the older WB value is stale too, so
    // fall back to the regfile rather than forward the wrong thing.
    if (w_mem_hit)     o_sel = i_mem_load ? 2'b00 : 2'b01;
    else if (w_wb_hit) o_sel = 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int AW     = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  pipe_hazard_ctrl_if.slave io_hz
);
  localparam int NSRC = 2;

  // EX shadow keeps the source fields so forwarding can be decided from
  // registered state while the instruction executes.
  typedef struct packed {
    logic                      v;
    logic [AW-1:0]             wa;
    logic                      load;
    logic [NSRC-1:0]           sen;
    logic [NSRC-1:0][AW-1:0]   src;
  } ex_slot_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] wa;
    logic          load;
  } mem_slot_t;

  // WB only needs the destination; nothing downstream asks whether it
  // was a load.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] wa;
  } wb_slot_t;

  ex_slot_t  r_ex;
  mem_slot_t r_mem;
  wb_slot_t  r_wb;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [NSRC-1:0]         w_ra_en;
  logic [NSRC-1:0][AW-1:0] w_ra;
  logic [NSRC-1:0]         w_hit_ex;
  logic [NSRC-1:0]         w_hit_mem;
  logic [NSRC-1:0]         w_hit_wb;
  logic [NSRC-1:0][1:0]    w_fwd_sel;
  logic                    w_stall;
  logic                    w_kill;
  logic                    w_advance;
  ex_slot_t                w_ex_nxt;

  assign w_ra_en = {io_hz.i_id_ra1_en, io_hz.i_id_ra0_en};
  assign w_ra    = {io_hz.i_id_ra1,    io_hz.i_id_ra0};

  // ---- RAW detection against each in-flight shadow, per ID source ----
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic w_rd;
    assign w_rd         = io_hz.i_id_valid & w_ra_en[s];
    assign w_hit_ex[s]  = w_rd & r_ex.v  & (r_ex.wa  == w_ra[s]);
    assign w_hit_mem[s] = w_rd & r_mem.v & (r_mem.wa == w_ra[s]);
    assign w_hit_wb[s]  = w_rd & r_wb.v  & (r_wb.wa  == w_ra[s]);

    pipe_hazard_fwd_sel #(.AW(AW)) u_fwd_sel (
      .i_src_en   (r_ex.sen[s]),
      .i_src      (r_ex.src[s]),
      .i_mem_v    (r_mem.v),
      .i_mem_load (r_mem.load),
      .i_mem_wa   (r_mem.wa),
      .i_wb_v     (r_wb.v),
      .i_wb_wa    (r_wb.wa),
      .o_sel      (w_fwd_sel[s])
    );
  end

  // With forwarding only a load directly ahead is a hazard; without it any
  // producer still in EX/MEM/WB is (the regfile write lands as it leaves WB).
  assign w_stall = FWD_EN ? ((|w_hit_ex) & r_ex.load)
                          : (|(w_hit_ex | w_hit_mem | w_hit_wb));

  assign w_kill    = w_stall | io_hz.i_ex_br_taken;
  assign w_advance = ~io_hz.i_mem_busy;

  // ---- next EX shadow: the ID instruction, or a bubble ----
  always_comb begin
    w_ex_nxt = '0;
    if (!w_kill) begin
      w_ex_nxt.v    = io_hz.i_id_valid & io_hz.i_id_wen;
      w_ex_nxt.wa   = io_hz.i_id_wa;
      w_ex_nxt.load = io_hz.i_id_valid & io_hz.i_id_wen & io_hz.i_id_load;
      w_ex_nxt.sen  = w_ra_en & {NSRC{io_hz.i_id_valid}};
      w_ex_nxt.src  = w_ra;
    end
  end

  // ---- shadow pipeline; frozen edges hold every slot ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (w_advance) begin
      r_ex  <= w_ex_nxt;
      r_mem <= '{v: r_ex.v, wa: r_ex.wa, load: r_ex.load};
      r_wb  <= '{v: r_mem.v, wa: r_mem.wa};
    end
  end

  // ---- pipeline control, priority freeze > branch > stall > run ----
  always_comb begin
    io_hz.o_pc_en       = 1'b0;
    io_hz.o_ifid_en     = 1'b0;
    io_hz.o_ifid_flush  = 1'b0;
    io_hz.o_idex_bubble = 1'b0;
    io_hz.o_pipe_freeze = 1'b0;
    if (i_rst) begin
      // everything quiet while reset is held
    end else if (io_hz.i_mem_busy) begin
      io_hz.o_pipe_freeze = 1'b1;
    end else if (io_hz.i_ex_br_taken) begin
      // PC loads the target; the wrong-path IF and ID instructions die.
      io_hz.o_pc_en       = 1'b1;
      io_hz.o_ifid_en     = 1'b1;
      io_hz.o_ifid_flush  = 1'b1;
      io_hz.o_idex_bubble = 1'b1;
    end else if (w_stall) begin
      io_hz.o_idex_bubble = 1'b1;
    end else begin
      io_hz.o_pc_en   = 1'b1;
      io_hz.o_ifid_en = 1'b1;
    end
  end

  assign io_hz.o_fwd_a = (i_rst || !FWD_EN) ? 2'b00 : w_fwd_sel[0];
  assign io_hz.o_fwd_b = (i_rst || !FWD_EN) ? 2'b00 : w_fwd_sel[1];

  // ---- saturating performance counters; clear beats increment ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (io_hz.i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_advance) begin
      if (io_hz.i_ex_br_taken) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_stall) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign io_hz.o_stall_cnt = r_stall_cnt;
  assign io_hz.o_flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  // control vector layout: {pc_en, ifid_en, ifid_flush, idex_bubble, freeze}
  localparam logic [4:0] C_RST = 5'b00000;
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00010;
  localparam logic [4:0] C_FRZ = 5'b00001;
  localparam logic [4:0] C_BR  = 5'b11110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.AW(5), .CNT_W(16)) hz1();
  pipe_hazard_ctrl_if #(.AW(5), .CNT_W(4))  hz0();

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .i_clk(clk), .i_rst(rst), .io_hz(hz1)
  );
  pipe_hazard_ctrl #(.AW(5), .FWD_EN(1'b0), .CNT_W(4)) u_nofwd (
    .i_clk(clk), .i_rst(rst), .io_hz(hz0)
  );

  logic [4:0] ctl1, ctl0;
  logic [3:0] fwd1, fwd0;
  assign ctl1 = {hz1.o_pc_en, hz1.o_ifid_en, hz1.o_ifid_flush, hz1.o_idex_bubble, hz1.o_pipe_freeze};
  assign ctl0 = {hz0.o_pc_en, hz0.o_ifid_en, hz0.o_ifid_flush, hz0.o_idex_bubble, hz0.o_pipe_freeze};
  assign fwd1 = {hz1.o_fwd_a, hz1.o_fwd_b};
  assign fwd0 = {hz0.o_fwd_a, hz0.o_fwd_b};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sel=1 drives the forwarding instance, sel=0 the non-forwarding one
  task automatic id(input bit sel, input bit v, input bit e0, input int r0,
                    input bit e1, input int r1, input bit w, input int wa, input bit ld);
    logic [4:0] a0, a1, aw;
    a0 = r0[4:0]; a1 = r1[4:0]; aw = wa[4:0];
    if (sel) begin
      hz1.i_id_valid = v; hz1.i_id_ra0_en = e0; hz1.i_id_ra0 = a0;
      hz1.i_id_ra1_en = e1; hz1.i_id_ra1 = a1;
      hz1.i_id_wen = w; hz1.i_id_wa = aw; hz1.i_id_load = ld;
    end else begin
      hz0.i_id_valid = v; hz0.i_id_ra0_en = e0; hz0.i_id_ra0 = a0;
      hz0.i_id_ra1_en = e1; hz0.i_id_ra1 = a1;
      hz0.i_id_wen = w; hz0.i_id_wa = aw; hz0.i_id_load = ld;
    end
  endtask

  initial begin
    rst = 1'b1;
    id(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz1.i_ex_br_taken = 1'b0; hz1.i_mem_busy = 1'b0; hz1.i_cnt_clr = 1'b0;
    hz0.i_ex_br_taken = 1'b0; hz0.i_mem_busy = 1'b0; hz0.i_cnt_clr = 1'b0;

    // ---- reset state ----
    repeat (2) cyc();
    #2;
    chk("rst_ctl1", ctl1, C_RST);
    chk("rst_ctl0", ctl0, C_RST);
    chk("rst_fwd1", fwd1, 0);
    chk("rst_stall1", hz1.o_stall_cnt, 0);
    chk("rst_flush1", hz1.o_flush_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_run", ctl1, C_RUN);
    cyc();

    // ---- ADD r3<-r1,r2 ; SUB r4<-r3,r5 : forward from EX/MEM ----
    id(1'b1, 1, 1, 1, 1, 2, 1, 3, 0); #2;
    chk("t1_add_run", ctl1, C_RUN);
    cyc();
    id(1'b1, 1, 1, 3, 1, 5, 1, 4, 0); #2;
    chk("t1_sub_nostall", ctl1, C_RUN);
    cyc();
    id(1'b1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t1_sub_fwd", fwd1, 4'b0100);
    cyc(); #2;
    chk("t1_drain_fwd", fwd1, 0);
    cyc();

    // ---- LD r7 ; ADD r8<-r7,r7 : one load-use stall then WB forward ----
    id(1'b1, 1, 1, 9, 0, 0, 1, 7, 1); #2;
    chk("t2_ld_run", ctl1, C_RUN);
    cyc();
    id(1'b1, 1, 1, 7, 1, 7, 1, 8, 0); #2;
    chk("t2_lu_stall", ctl1, C_STL);
    chk("t2_cnt_before", hz1.o_stall_cnt, 0);
    cyc(); #2;
    chk("t2_release", ctl1, C_RUN);
    chk("t2_stall_cnt", hz1.o_stall_cnt, 1);
    chk("t2_bubble_fwd", fwd1, 0);
    cyc();
    id(1'b1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t2_fwd_wb", fwd1, 4'b1010);
    cyc();

    // ---- load-use with MEM_BUSY held for 3 cycles ----
    id(1'b1, 1, 1, 9, 0, 0, 1, 7, 1); #2;
    cyc();
    id(1'b1, 1, 1, 7, 1, 7, 1, 8, 0);
    hz1.i_mem_busy = 1'b1; #2;
    chk("t3_frz1", ctl1, C_FRZ);
    cyc(); #2;
    chk("t3_frz2", ctl1, C_FRZ);
    cyc(); #2;
    chk("t3_frz3", ctl1, C_FRZ);
    chk("t3_cnt_hold", hz1.o_stall_cnt, 1);
    cyc();
    hz1.i_mem_busy = 1'b0; #2;
    chk("t3_stall", ctl1, C_STL);
    cyc(); #2;
    chk("t3_release", ctl1, C_RUN);
    chk("t3_stall_cnt", hz1.o_stall_cnt, 2);
    cyc();
    id(1'b1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t3_fwd_wb", fwd1, 4'b1010);
    cyc();

    // ---- taken branch beats a pending load-use stall ----
    id(1'b1, 1, 1, 9, 0, 0, 1, 7, 1); #2;
    cyc();
    id(1'b1, 1, 1, 7, 1, 7, 1, 8, 0);
    hz1.i_ex_br_taken = 1'b1; #2;
    chk("t4_br_ctl", ctl1, C_BR);
    cyc();
    hz1.i_ex_br_taken = 1'b0;
    id(1'b1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t4_flush_cnt", hz1.o_flush_cnt, 1);
    chk("t4_stall_cnt", hz1.o_stall_cnt, 2);
    chk("t4_killed_fwd", fwd1, 0);
    cyc();

    // ---- FWD_EN=0: ADD r3 ; SUB r4<-r3,r5 : three stalls ----
    id(1'b0, 1, 1, 1, 1, 2, 1, 3, 0); #2;
    chk("t5_add_run", ctl0, C_RUN);
    cyc();
    id(1'b0, 1, 1, 3, 1, 5, 1, 4, 0); #2;
    chk("t5_stall_ex", ctl0, C_STL);
    cyc(); #2;
    chk("t5_stall_mem", ctl0, C_STL);
    chk("t5_cnt1", hz0.o_stall_cnt, 1);
    cyc(); #2;
    chk("t5_stall_wb", ctl0, C_STL);
    chk("t5_fwd_off", fwd0, 0);
    cyc(); #2;
    chk("t5_release", ctl0, C_RUN);
    chk("t5_cnt3", hz0.o_stall_cnt, 3);
    cyc();
    id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t5_sub_fwd00", fwd0, 0);
    cyc();

    // ---- saturation of the 4-bit counter: 3 + 5*3 stalls -> 15 ----
    for (int k = 0; k < 5; k++) begin
      id(1'b0, 1, 1, 1, 1, 2, 1, 3, 0);
      cyc();
      id(1'b0, 1, 1, 3, 1, 5, 1, 4, 0);
      repeat (4) cyc();
    end
    id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t6_saturated", hz0.o_stall_cnt, 4'hF);
    cyc();

    // ---- CNT_CLR during a stall wins over the increment ----
    id(1'b0, 1, 1, 1, 1, 2, 1, 3, 0);
    cyc();
    id(1'b0, 1, 1, 3, 1, 5, 1, 4, 0);
    hz0.i_cnt_clr = 1'b1; #2;
    chk("t6_clr_stall", ctl0, C_STL);
    cyc();
    hz0.i_cnt_clr = 1'b0; #2;
    chk("t6_clr_wins", hz0.o_stall_cnt, 0);
    cyc(); #2;
    chk("t6_count_on", hz0.o_stall_cnt, 1);
    id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // ---- reset pulse in the middle of a load-use stall ----
    id(1'b1, 1, 1, 9, 0, 0, 1, 7, 1); #2;
    cyc();
    id(1'b1, 1, 1, 7, 1, 7, 1, 8, 0); #2;
    chk("t7_pre_stall", ctl1, C_STL);
    rst = 1'b1; #1;
    chk("t7_rst_ctl", ctl1, C_RST);
    chk("t7_rst_stall", hz1.o_stall_cnt, 0);
    chk("t7_rst_flush", hz1.o_flush_cnt, 0);
    chk("t7_rst_cnt0", hz0.o_stall_cnt, 0);
    cyc();
    rst = 1'b0; #2;
    chk("t7_no_stall", ctl1, C_RUN);
    cyc(); #2;
    chk("t7_cnt_zero", hz1.o_stall_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
